mux4_rr_arbiter: RTL

- Round-robin arbiter that shares one 4:1 WIDTH-bit mux path among four requesters.
- Chooses an owner, drives the mux select, and registers the selected data into a single-entry output stage with valid/ready backpressure.
- An owner may hold the path for a burst of up to MAX_BURST beats; ownership then rotates.
- Sits in front of the 4:1 mux datapath and replaces static s1/s0 tie-offs with scheduled selection.

---
 rtl/mux4_rr_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 mux path, with bursts capped at
// MAX_BURST beats and a single-entry registered output stage with valid/ready.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             load;
    logic             found;
    logic [1:0]       win;
    logic [1:0]       scan_idx;
    logic             grant_en;
    logic [1:0]       grant_idx;
    logic [WIDTH-1:0] mux_data;

    // First requester at or after ptr, wrapping 3 -> 0.
    always_comb begin
        found    = 1'b0;
        win      = 2'd0;
        scan_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        grant_en    = 1'b0;
        grant_idx   = owner_q;
        load        = !out_valid_q || out_ready;

        case (state_q)
            IDLE: begin
                if (load && found) begin
                    grant_en  = 1'b1;
                    grant_idx = win;
                    owner_d   = win;
                    cnt_d     = 4'd1;
                    if (MAX_BURST == 1) begin
                        ptr_d = win + 2'd1;
                    end else begin
                        state_d = OWN;
                    end
                end
            end
            OWN: begin
                // A stalled output freezes the burst even if the owner dropped req.
                if (load) begin
                    if (req[owner_q]) begin
                        grant_en  = 1'b1;
                        grant_idx = owner_q;
                        cnt_d     = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == BURST_MAX) begin
                            state_d = IDLE;
                            ptr_d   = owner_q + 2'd1;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        state_d = IDLE;
                        ptr_d   = owner_q + 2'd1;
                        cnt_d   = 4'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        case (grant_idx)
            2'd0:    mux_data = din0;
            2'd1:    mux_data = din1;
            2'd2:    mux_data = din2;
            default: mux_data = din3;
        endcase
    end

    always_comb begin
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (grant_en) begin
            sel_d       = grant_idx;
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            owner_q     <= 2'd0;
            cnt_q       <= 4'd0;
            sel_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Grant is gated by rst_n so nothing is consumed while reset is held.
    assign gnt       = (grant_en && rst_n) ? (4'b0001 << grant_idx) : 4'b0000;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == OWN);

endmodule
